// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
//   arb_state_t : arbiter FSM state (IDLE between packets, BUSY while a packet is granted).
//   rr_pick     : round-robin first-set search over up to MAX_SRC requesters.
//   MAX_SRC     : largest requester count the helpers support.
package axis_arb_pkg;

    localparam int unsigned MAX_SRC   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;

    // Returns {found, idx}: the first asserted bit of req[n-1:0], scanning
    // ptr, ptr+1, ... and wrapping from n-1 back to 0. ptr must be below n.
    function automatic logic [MAX_IDX_W:0] rr_pick(input logic [MAX_SRC-1:0]   req,
                                                   input logic [MAX_IDX_W-1:0] ptr,
                                                   input int unsigned          n);
        logic [MAX_IDX_W:0] res;
        logic [MAX_IDX_W:0] idx;
        res = '0;
        for (int unsigned k = 0; k < MAX_SRC; k++) begin
            // ptr + k stays below 2n, so one conditional subtract is the whole modulo.
            idx = {1'b0, ptr} + (MAX_IDX_W + 1)'(k);
            if (idx >= (MAX_IDX_W + 1)'(n)) begin
                idx = idx - (MAX_IDX_W + 1)'(n);
            end
            if ((k < n) && !res[MAX_IDX_W] && req[idx[MAX_IDX_W-1:0]]) begin
                res = {1'b1, idx[MAX_IDX_W-1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_picker.sv
// Round-robin picker: combinational rotate/priority-encode of N_SRC requests.
//   req_i   : request vector.
//   ptr_i   : search start index (highest priority).
//   found_o : at least one request is set.
//   idx_o   : first requester at or after ptr_i, wrapping modulo N_SRC.
module rr_picker
    import axis_arb_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [MAX_SRC-1:0]   req_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    logic [MAX_IDX_W:0]   pick;

    always_comb begin
        req_ext               = '0;
        req_ext[N_SRC-1:0]    = req_i;
        ptr_ext               = '0;
        ptr_ext[IDX_W-1:0]    = ptr_i;
        pick                  = rr_pick(req_ext, ptr_ext, N_SRC);
    end

    assign found_o = pick[MAX_IDX_W];
    assign idx_o   = IDX_W'(pick[MAX_IDX_W-1:0]);

endmodule

// File: rtl/axis_packet_arbiter.sv
// N-input AXI-Stream packet arbiter. A round-robin grant is held for a whole
// packet (first beat to s_last); one IDLE arbitration cycle separates packets.
// The granted input is passed through combinationally, with no buffering.
//   clk_i/rst_i           : clock, synchronous active-high reset.
//   s_valid_i/s_ready_o   : per-input handshake; s_last_i/s_keep_i/s_data_i per-input beat.
//   m_valid_o/m_ready_i   : output handshake; m_last_o/m_keep_o/m_data_o output beat.
//   busy_o                : a packet is currently granted.
// Optional (macro AXIS_ARB_ID_EN): m_id_o = granted input while busy, pkt_cnt_o = packets
// completed since reset (wraps at 2^32).
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned  N_SRC          = 4,
    parameter int unsigned  WORD_W         = 8,
    parameter int unsigned  BUS_W          = 8,
    localparam int unsigned WORDS_PER_BEAT = BUS_W / WORD_W,
    localparam int unsigned IDX_W          = $clog2(N_SRC)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [N_SRC-1:0]                             s_valid_i,
    output logic [N_SRC-1:0]                             s_ready_o,
    input  logic [N_SRC-1:0]                             s_last_i,
    input  logic [N_SRC-1:0][WORDS_PER_BEAT-1:0]         s_keep_i,
    input  logic [N_SRC-1:0][WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data_i,
    output logic                                         m_valid_o,
    input  logic                                         m_ready_i,
    output logic                                         m_last_o,
    output logic [WORDS_PER_BEAT-1:0]                    m_keep_o,
    output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]        m_data_o,
`ifdef AXIS_ARB_ID_EN
    output logic [IDX_W-1:0]                             m_id_o,
    output logic [31:0]                                  pkt_cnt_o,
`endif
    output logic                                         busy_o
);

    arb_state_t       state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic             busy_q;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] rr_ptr_d;
    logic             last_hs;
`ifdef AXIS_ARB_ID_EN
    logic [31:0]      pkt_cnt_q;
`endif

    rr_picker #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req_i   (s_valid_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Pass-through of the granted input; everything forced to 0 unless a beat
    // is actually valid so idle sources never leak X downstream.
    always_comb begin
        s_ready_o = '0;
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        m_keep_o  = '0;
        m_data_o  = '0;
        if (state_q == BUSY) begin
            s_ready_o[grant_q] = m_ready_i;
            if (s_valid_i[grant_q]) begin
                m_valid_o = 1'b1;
                m_last_o  = s_last_i[grant_q];
                m_keep_o  = s_keep_i[grant_q];
                m_data_o  = s_data_i[grant_q];
            end
        end
    end

    assign last_hs  = m_valid_o & m_ready_i & m_last_o;
    assign rr_ptr_d = (grant_q == IDX_W'(N_SRC - 1)) ? '0 : grant_q + IDX_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            busy_q    <= 1'b0;
`ifdef AXIS_ARB_ID_EN
            pkt_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    // A granted source that stalls mid-packet keeps the lock.
                    if (last_hs) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        rr_ptr_q  <= rr_ptr_d;
`ifdef AXIS_ARB_ID_EN
                        pkt_cnt_q <= pkt_cnt_q + 32'd1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

`ifdef AXIS_ARB_ID_EN
    assign m_id_o    = (state_q == BUSY) ? grant_q : '0;
    assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
`timescale 1ns/1ps
module tb_axis_packet_arbiter;

    localparam int N   = 4;
    localparam int WW  = 8;
    localparam int BW  = 16;
    localparam int WPB = BW / WW;

    typedef struct packed {
        logic           last;
        logic [WPB-1:0] keep;
        logic [BW-1:0]  data;
    } beat_t;

    typedef struct {
        int    cyc;
        beat_t b;
    } rx_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [N-1:0]                  s_valid = '0;
    logic [N-1:0]                  s_ready;
    logic [N-1:0]                  s_last = '0;
    logic [N-1:0][WPB-1:0]         s_keep = '0;
    logic [N-1:0][WPB-1:0][WW-1:0] s_data = '0;
    logic                          m_valid;
    logic                          m_ready = 1'b0;
    logic                          m_last;
    logic [WPB-1:0]                m_keep;
    logic [WPB-1:0][WW-1:0]        m_data;
    logic                          busy;
`ifdef AXIS_ARB_ID_EN
    logic [1:0]                    m_id;
    logic [31:0]                   pkt_cnt;
`endif

    axis_packet_arbiter #(
        .N_SRC  (N),
        .WORD_W (WW),
        .BUS_W  (BW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_last_i  (s_last),
        .s_keep_i  (s_keep),
        .s_data_i  (s_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_last_o  (m_last),
        .m_keep_o  (m_keep),
        .m_data_o  (m_data),
`ifdef AXIS_ARB_ID_EN
        .m_id_o    (m_id),
        .pkt_cnt_o (pkt_cnt),
`endif
        .busy_o    (busy)
    );

    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    int          vld_pct = 100;
    int          rdy_pct = 100;
    logic [N-1:0] acc = '0;
    beat_t       srcq[N][$];
    beat_t       exp_q[N][$];
    int          order[$];
    rx_t         rx_log[$];
    int          rx_pk[N];

    // Packet-level model: owner of the bus, round-robin pointer, completed count.
    bit          mb = 1'b0;
    int          mo = 0;
    int          mp = 0;
    int unsigned mcnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Upper word carries the source id in its top two bits so the sink can
    // route each received beat back to the packet it belongs to.
    task automatic push_pkt(input int src, input int nb, input logic [WPB-1:0] lk);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.last = (i == nb - 1);
            b.keep = (i == nb - 1) ? lk : '1;
            b.data = {2'(src), 6'($urandom), 8'($urandom)};
            srcq[src].push_back(b);
            exp_q[src].push_back(b);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            exp_q[i].delete();
        end
        s_valid = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = !mb;
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
            end
        end
        chk(nm, 64'(done), 64'd1);
    endtask

    // Source drivers: AXIS-legal (a presented beat holds until accepted).
    initial begin : p_drv
        beat_t b;
        logic  hold;
        forever begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(99) < rdy_pct);
            for (int i = 0; i < N; i++) begin
                if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                hold = s_valid[i] && !acc[i];
                if (srcq[i].size() == 0) begin
                    s_valid[i] = 1'b0;
                end else if (!hold) begin
                    s_valid[i] = ($urandom_range(99) < vld_pct);
                end
                if (s_valid[i]) begin
                    b         = srcq[i][0];
                    s_last[i] = b.last;
                    s_keep[i] = b.keep;
                    s_data[i] = b.data;
                end else begin
                    s_last[i] = 1'bx;
                    s_keep[i] = 'x;
                    s_data[i] = 'x;
                end
            end
        end
    end

    // Per-cycle compare, sink reassembly and model update, all at the negedge.
    initial begin : p_cmp
        logic          evalid;
        logic [N-1:0]  eready;
        beat_t         b;
        beat_t         e;
        int            src;
        bit            fnd;
        forever begin
            @(negedge clk);
            cyc++;
            acc = s_valid & s_ready;
            if (chk_en) begin
                evalid = mb && s_valid[mo];
                eready = '0;
                if (mb) eready[mo] = m_ready;
                chk("m_valid", 64'(m_valid), 64'(evalid));
                chk("s_ready", 64'(s_ready), 64'(eready));
                chk("m_last", 64'(m_last), evalid ? 64'(s_last[mo]) : 64'd0);
                chk("m_keep", 64'(m_keep), evalid ? 64'(s_keep[mo]) : 64'd0);
                chk("m_data", 64'(m_data), evalid ? 64'(s_data[mo]) : 64'd0);
                chk("busy", 64'(busy), 64'(mb));
`ifdef AXIS_ARB_ID_EN
                chk("m_id", 64'(m_id), mb ? 64'(mo) : 64'd0);
                chk("pkt_cnt", 64'(pkt_cnt), 64'(mcnt));
`endif
                if (m_valid === 1'b1 && m_ready) begin
                    b   = {m_last, m_keep, m_data};
                    src = int'(m_data[WPB-1][WW-1 -: 2]);
                    rx_log.push_back('{cyc, b});
                    chk("sink_pending", 64'(exp_q[src].size() > 0), 64'd1);
                    if (exp_q[src].size() > 0) begin
                        e = exp_q[src].pop_front();
                        chk("sink_beat", 64'(b), 64'(e));
                        if (b.last) rx_pk[src]++;
                    end
`ifdef AXIS_ARB_ID_EN
                    chk("m_id_tag", 64'(m_id), 64'(src));
`endif
                end
            end
            if (rst) begin
                mb = 1'b0;
                mo = 0;
                mp = 0;
                mcnt = 0;
            end else if (!mb) begin
                fnd = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!fnd && s_valid[(mp + k) % N]) begin
                        fnd = 1'b1;
                        mo  = (mp + k) % N;
                    end
                end
                mb = fnd;
            end else if (s_valid[mo] && m_ready && s_last[mo]) begin
                order.push_back(mo);
                mb = 1'b0;
                mp = (mo + 1) % N;
                mcnt++;
            end
        end
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int t0;
        int n;
        int exp3[5];
        int srcs7[7];
        exp3  = '{2, 3, 0, 3, 0};
        srcs7 = '{0, 1, 2, 3, 1, 2, 0};

        // Reset state.
        do_reset();
        chk_en = 1'b1;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_keep", 64'(m_keep), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
`ifdef AXIS_ARB_ID_EN
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif

        // Single source, 5 words on a 2-word bus: 3 beats, keep 11,11,01.
        rx_log.delete();
        push_pkt(2, 3, 2'b01);
        n = 0;
        while (s_valid[2] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        t0 = cyc;
        wait_drain("t1_drain", 200);
        chk("t1_beats", 64'(rx_log.size()), 64'd3);
        if (rx_log.size() == 3) begin
            chk("t1_bubble", 64'(rx_log[0].cyc - t0), 64'd1);
            chk("t1_gap1", 64'(rx_log[1].cyc - rx_log[0].cyc), 64'd1);
            chk("t1_gap2", 64'(rx_log[2].cyc - rx_log[1].cyc), 64'd1);
            chk("t1_keep0", 64'(rx_log[0].b.keep), 64'h3);
            chk("t1_keep1", 64'(rx_log[1].b.keep), 64'h3);
            chk("t1_keep2", 64'(rx_log[2].b.keep), 64'h1);
            chk("t1_last0", 64'(rx_log[0].b.last), 64'd0);
            chk("t1_last1", 64'(rx_log[1].b.last), 64'd0);
            chk("t1_last2", 64'(rx_log[2].b.last), 64'd1);
        end

        // All inputs continuously requesting 2-beat packets.
        do_reset();
        order.delete();
        for (int s = 0; s < N; s++) rx_pk[s] = 0;
        for (int p = 0; p < 10; p++) begin
            for (int s = 0; s < N; s++) push_pkt(s, 2, 2'b11);
        end
        wait_drain("t2_drain", 2000);
        chk("t2_count", 64'(order.size()), 64'd40);
        for (int k = 0; k < order.size(); k++) chk("t2_order", 64'(order[k]), 64'(k % 4));
        for (int s = 0; s < N; s++) chk("t2_per_src", 64'(rx_pk[s]), 64'd10);

        // Fairness wrap: pointer parked at 3, only inputs 3 and 0 request.
        do_reset();
        order.delete();
        push_pkt(2, 1, 2'b11);
        wait_drain("t3_pre_drain", 200);
        push_pkt(3, 1, 2'b11);
        push_pkt(0, 1, 2'b01);
        push_pkt(3, 1, 2'b11);
        push_pkt(0, 1, 2'b01);
        wait_drain("t3_drain", 400);
        chk("t3_count", 64'(order.size()), 64'd5);
        for (int k = 0; k < 5 && k < order.size(); k++) chk("t3_order", 64'(order[k]), 64'(exp3[k]));

        // Backpressure with sparse valids and random packet shapes.
        do_reset();
        for (int s = 0; s < N; s++) rx_pk[s] = 0;
        vld_pct = 20;
        rdy_pct = 70;
        for (int s = 0; s < N; s++) begin
            for (int p = 0; p < 5; p++) push_pkt(s, 1 + $urandom_range(3), 2'($urandom_range(3, 1)));
        end
        wait_drain("t4_drain", 8000);
        for (int s = 0; s < N; s++) chk("t4_per_src", 64'(rx_pk[s]), 64'd5);
        vld_pct = 100;
        rdy_pct = 100;

        // Reset while beat 2 of a 4-beat packet from input 1 is on the bus.
        do_reset();
        order.delete();
        rx_log.delete();
        push_pkt(1, 4, 2'b11);
        n = 0;
        while (rx_log.size() < 1 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_first_beat", 64'(rx_log.size()), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        srcq[1].delete();
        exp_q[1].delete();
        s_valid[1] = 1'b0;
        tick();
        chk("t5_m_valid", 64'(m_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_s_ready", 64'(s_ready), 64'd0);
        push_pkt(3, 2, 2'b11);
        wait_drain("t5_drain", 200);
        chk("t5_count", 64'(order.size()), 64'd1);
        if (order.size() == 1) chk("t5_winner", 64'(order[0]), 64'd3);

`ifdef AXIS_ARB_ID_EN
        // Mixed sources with id and packet counter.
        do_reset();
        for (int k = 0; k < 7; k++) push_pkt(srcs7[k], 1 + (k % 3), 2'b11);
        wait_drain("t6_drain", 500);
        chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd7);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
